// File: rtl/aud_pkg.sv
// ---------------------------------------------------------------------------
// aud_pkg
//   Shared definitions for the audio playback sequencer:
//     - default SRAM address / sample widths
//     - playback FSM state encoding (3 bits, also exported on o_state)
//     - RECIP table: round(1024 / N) for speed factors N = 1..8,
//       indexed by N-1
//     - saturate16: clamp a wide signed value into the 16-bit sample range
// ---------------------------------------------------------------------------
package aud_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_LR = 3'd1,
      ST_FETCH   = 3'd2,
      ST_CALC    = 3'd3,
      ST_HOLD    = 3'd4,
      ST_PAUSE   = 3'd5
   } state_e;

   // Element [i] holds 1024/(i+1), so the table is addressed with N-1.
   localparam logic [7:0][10:0] RECIP = {
      11'd128, 11'd146, 11'd171, 11'd205,
      11'd256, 11'd341, 11'd512, 11'd1024
   };

   function automatic logic signed [15:0] saturate16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         return 16'sh7FFF;
      else if (v < -32'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

endpackage

// File: rtl/aud_interp.sv
// ---------------------------------------------------------------------------
// aud_interp
//   Combinational linear interpolator between two consecutive samples.
//   o_sample = sat16( prev + ((cur - prev) * k * RECIP[N-1]) >>> 10 )
//   The shift is arithmetic, so the fractional part rounds toward -inf.
//
// Ports
//   i_prev    in  16  previous sample (signed)
//   i_cur     in  16  current sample (signed)
//   i_k       in  3   phase within the sample, 0..N-1
//   i_n_m1    in  3   speed factor minus one (N-1), 0..7
//   o_sample  out 16  interpolated, saturated sample (signed)
// ---------------------------------------------------------------------------
module aud_interp
   import aud_pkg::*;
(
   input  logic signed [15:0] i_prev,
   input  logic signed [15:0] i_cur,
   input  logic        [2:0]  i_k,
   input  logic        [2:0]  i_n_m1,
   output logic signed [15:0] o_sample
);

   logic signed [16:0] w_diff;
   logic signed [31:0] w_prod;
   logic signed [31:0] w_sum;

   // A 17-bit difference holds any pair of 16-bit samples without wrap.
   assign w_diff = 17'(i_cur) - 17'(i_prev);

   // |diff| * 7 * 1024 < 2^29, so a 32-bit signed product cannot overflow.
   assign w_prod = 32'(w_diff)
                 * 32'($signed({1'b0, i_k}))
                 * 32'($signed({1'b0, RECIP[i_n_m1]}));

   assign w_sum    = 32'(i_prev) + (w_prod >>> 10);
   assign o_sample = saturate16(w_sum);

endmodule

// File: rtl/aud_play_ctrl.sv
// ---------------------------------------------------------------------------
// aud_play_ctrl
//   Playback sequencer feeding the I2S DAC serializer. Walks SRAM sample
//   addresses through a req/ack read port and applies speed control:
//   fast mode skips N-1 samples per frame, slow mode repeats each sample
//   for N frames (zero-order hold) or interpolates linearly towards it.
//   One sample is presented per LRCK frame; it is set up while LRCK is
//   high and held stable while LRCK is low (the serializer's half).
//
// Ports
//   i_bclk       in  1       audio bit clock
//   i_rst_n      in  1       asynchronous active-low reset
//   i_daclrck    in  1       DAC LR clock, low = left half (transmit half)
//   i_start      in  1       pulse: begin playback from address 0
//   i_pause      in  1       level: hold playback at a frame boundary
//   i_stop       in  1       pulse: abort playback (wins over i_start)
//   i_fast       in  1       1 = fast mode, 0 = normal/slow
//   i_interp     in  1       slow mode: 1 = linear, 0 = zero-order hold
//   i_speed      in  3       speed factor N = i_speed + 1
//   i_end_addr   in  ADDR_W  last valid sample address (inclusive)
//   o_sram_req   out 1       read request, held until i_sram_ack
//   o_sram_addr  out ADDR_W  read address
//   i_sram_ack   in  1       read complete, i_sram_data valid
//   i_sram_data  in  DATA_W  read data
//   o_en         out 1       enable to the DAC serializer
//   o_dac_data   out DATA_W  sample to the serializer
//   o_addr       out ADDR_W  current play address
//   o_done       out 1       one-cycle pulse at end of data or on stop
//   o_state      out 3       FSM state
// ---------------------------------------------------------------------------
module aud_play_ctrl
   import aud_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_daclrck,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic              i_fast,
   input  logic              i_interp,
   input  logic [2:0]        i_speed,
   input  logic [ADDR_W-1:0] i_end_addr,
   output logic              o_sram_req,
   output logic [ADDR_W-1:0] o_sram_addr,
   input  logic              i_sram_ack,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic              o_en,
   output logic [DATA_W-1:0] o_dac_data,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_done,
   output logic [2:0]        o_state
);

   state_e                   r_state;
   logic                     r_lrck_q;
   logic [ADDR_W-1:0]        r_addr;
   logic [2:0]               r_k;
   logic [3:0]               r_n_lat;
   logic                     r_fast;
   logic                     r_interp;
   logic signed [DATA_W-1:0] r_prev;
   logic signed [DATA_W-1:0] r_cur;
   logic                     r_first;
   logic                     r_stop_pend;
   logic                     r_late;
   logic                     r_req;
   logic                     r_en;
   logic [DATA_W-1:0]        r_dac_data;
   logic                     r_done;

   logic                     w_rise;
   logic [2:0]               w_n_m1;
   logic [3:0]               w_n_in;
   logic                     w_k_wrap;
   logic [ADDR_W:0]          w_next;
   logic                     w_past_end;
   logic signed [DATA_W-1:0] w_interp;
   logic [DATA_W-1:0]        w_calc;

   assign w_rise = i_daclrck & ~r_lrck_q;
   assign w_n_m1 = 3'(r_n_lat - 4'd1);
   assign w_n_in = {1'b0, i_speed} + 4'd1;

   // In slow/normal mode a new sample is due once the phase reaches N-1.
   assign w_k_wrap = (r_k == w_n_m1);

   // One bit wider than the address so the end check sees a carry-out.
   assign w_next = {1'b0, r_addr}
                 + (r_fast ? {{(ADDR_W-3){1'b0}}, r_n_lat}
                           : {{ADDR_W{1'b0}}, 1'b1});
   assign w_past_end = (w_next > {1'b0, i_end_addr});

   aud_interp u_interp (
      .i_prev   (r_prev),
      .i_cur    (r_cur),
      .i_k      (r_k),
      .i_n_m1   (w_n_m1),
      .o_sample (w_interp)
   );

   assign w_calc = (r_fast || !r_interp) ? r_cur : w_interp;

   // NOTE: clocked state uses non-blocking assignments only, so every
   // register in this block sees the values from before the edge.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_lrck_q    <= 1'b0;
         r_addr      <= '0;
         r_k         <= '0;
         r_n_lat     <= 4'd1;
         r_fast      <= 1'b0;
         r_interp    <= 1'b0;
         r_prev      <= '0;
         r_cur       <= '0;
         r_first     <= 1'b0;
         r_stop_pend <= 1'b0;
         r_late      <= 1'b0;
         r_req       <= 1'b0;
         r_en        <= 1'b0;
         r_dac_data  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_lrck_q <= i_daclrck;
         r_done   <= 1'b0;

         // Stop aborts anywhere except mid-read; a pending read always
         // completes its handshake before the abort is applied.
         if (i_stop && r_state != ST_FETCH) begin
            r_state     <= ST_IDLE;
            r_en        <= 1'b0;
            r_dac_data  <= '0;
            r_done      <= 1'b1;
            r_stop_pend <= 1'b0;
            r_late      <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (i_start) begin
                     r_addr   <= '0;
                     r_k      <= '0;
                     r_n_lat  <= w_n_in;
                     r_fast   <= i_fast;
                     r_interp <= i_interp;
                     r_first  <= 1'b1;
                     r_late   <= 1'b0;
                     r_req    <= 1'b1;
                     r_state  <= ST_FETCH;
                  end
               end

               ST_WAIT_LR: begin
                  if (w_rise) begin
                     if (i_pause) begin
                        r_en       <= 1'b0;
                        r_dac_data <= '0;
                        r_state    <= ST_PAUSE;
                     end else if (r_late) begin
                        // The read finished after the previous fall; the
                        // old sample played again, present the new one now.
                        r_late  <= 1'b0;
                        r_state <= ST_CALC;
                     end else if (r_fast || w_k_wrap) begin
                        r_k      <= '0;
                        r_n_lat  <= w_n_in;
                        r_fast   <= i_fast;
                        r_interp <= i_interp;
                        if (w_past_end) begin
                           r_en       <= 1'b0;
                           r_dac_data <= '0;
                           r_done     <= 1'b1;
                           r_state    <= ST_IDLE;
                        end else begin
                           r_addr  <= w_next[ADDR_W-1:0];
                           r_req   <= 1'b1;
                           r_state <= ST_FETCH;
                        end
                     end else begin
                        r_k     <= r_k + 3'd1;
                        r_state <= ST_CALC;
                     end
                  end
               end

               ST_FETCH: begin
                  if (i_stop)
                     r_stop_pend <= 1'b1;
                  if (i_sram_ack) begin
                     r_req <= 1'b0;
                     if (i_stop || r_stop_pend) begin
                        r_stop_pend <= 1'b0;
                        r_en        <= 1'b0;
                        r_dac_data  <= '0;
                        r_done      <= 1'b1;
                        r_state     <= ST_IDLE;
                     end else begin
                        r_prev  <= r_first ? '0 : r_cur;
                        r_cur   <= i_sram_data;
                        r_first <= 1'b0;
                        r_state <= ST_CALC;
                     end
                  end
               end

               ST_CALC: begin
                  // Only update the output while the serializer is idle
                  // (LRCK high); otherwise defer to the next frame.
                  if (i_daclrck) begin
                     r_dac_data <= w_calc;
                     r_en       <= 1'b1;
                     r_state    <= ST_HOLD;
                  end else begin
                     r_late  <= 1'b1;
                     r_state <= ST_WAIT_LR;
                  end
               end

               ST_HOLD: begin
                  if (!i_daclrck)
                     r_state <= ST_WAIT_LR;
               end

               ST_PAUSE: begin
                  if (!i_pause)
                     r_state <= ST_WAIT_LR;
               end

               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_sram_req  = r_req;
   assign o_sram_addr = r_addr;
   assign o_en        = r_en;
   assign o_dac_data  = r_dac_data;
   assign o_addr      = r_addr;
   assign o_done      = r_done;
   assign o_state     = r_state;

endmodule

// File: tb/tb_aud_play_ctrl.sv
`timescale 1ns/1ps
module tb_aud_play_ctrl;
   import aud_pkg::*;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;
   localparam int HALF   = 16;   // bclk cycles per LRCK half

   logic              i_bclk      = 1'b0;
   logic              i_rst_n     = 1'b0;
   logic              i_daclrck   = 1'b0;
   logic              i_start     = 1'b0;
   logic              i_pause     = 1'b0;
   logic              i_stop      = 1'b0;
   logic              i_fast      = 1'b0;
   logic              i_interp    = 1'b0;
   logic [2:0]        i_speed     = '0;
   logic [ADDR_W-1:0] i_end_addr  = '0;
   logic              i_sram_ack  = 1'b0;
   logic [DATA_W-1:0] i_sram_data = '0;
   logic              o_sram_req;
   logic [ADDR_W-1:0] o_sram_addr;
   logic              o_en;
   logic [DATA_W-1:0] o_dac_data;
   logic [ADDR_W-1:0] o_addr;
   logic              o_done;
   logic [2:0]        o_state;

   logic signed [15:0] t_prev = '0;
   logic signed [15:0] t_cur  = '0;
   logic        [2:0]  t_k    = '0;
   logic        [2:0]  t_n_m1 = '0;
   logic signed [15:0] t_out;

   aud_play_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .i_bclk      (i_bclk),
      .i_rst_n     (i_rst_n),
      .i_daclrck   (i_daclrck),
      .i_start     (i_start),
      .i_pause     (i_pause),
      .i_stop      (i_stop),
      .i_fast      (i_fast),
      .i_interp    (i_interp),
      .i_speed     (i_speed),
      .i_end_addr  (i_end_addr),
      .o_sram_req  (o_sram_req),
      .o_sram_addr (o_sram_addr),
      .i_sram_ack  (i_sram_ack),
      .i_sram_data (i_sram_data),
      .o_en        (o_en),
      .o_dac_data  (o_dac_data),
      .o_addr      (o_addr),
      .o_done      (o_done),
      .o_state     (o_state)
   );

   aud_interp u_interp_ut (
      .i_prev   (t_prev),
      .i_cur    (t_cur),
      .i_k      (t_k),
      .i_n_m1   (t_n_m1),
      .o_sample (t_out)
   );

   int checks = 0;
   int errors = 0;

   int mem [64];
   int recip_tb [8] = '{1024, 512, 341, 256, 205, 171, 146, 128};
   int exp_q[$];
   int exp_addr_q[$];
   int cap_q[$];
   int fetch_q[$];
   int done_cnt = 0;
   int unstable = 0;
   int fall_val = 0;
   int lr_cnt   = 0;
   int ack_wait = 0;
   bit hold_ack = 1'b0;

   always #5 i_bclk = ~i_bclk;

   // NOTE: bench inputs change on the falling edge so the DUT never sees
   // them racing its rising-edge sampling.
   // LRCK generator plus serializer model: the sample taken is whatever is
   // on o_dac_data during the low half, recorded at the end of that half.
   always @(negedge i_bclk) begin
      if (lr_cnt == HALF-1) begin
         lr_cnt = 0;
         if (i_daclrck) begin
            fall_val = int'($signed(o_dac_data));
         end else if (o_en) begin
            cap_q.push_back(int'($signed(o_dac_data)));
            if (int'($signed(o_dac_data)) != fall_val)
               unstable++;
         end
         i_daclrck = ~i_daclrck;
      end else begin
         lr_cnt++;
      end
      if (o_done)
         done_cnt++;
   end

   // SRAM responder: acks each request after 0..3 idle cycles.
   always @(negedge i_bclk) begin
      if (i_sram_ack) begin
         i_sram_ack = 1'b0;
      end else if (o_sram_req && !hold_ack) begin
         if (ack_wait == 0) begin
            i_sram_ack  = 1'b1;
            i_sram_data = 16'(mem[o_sram_addr[5:0]]);
            fetch_q.push_back(int'(o_sram_addr));
            ack_wait = int'($urandom_range(0, 3));
         end else begin
            ack_wait--;
         end
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference interpolation: prev + floor((cur-prev)*k*RECIP/1024), clamped.
   function automatic int interp_model(input int prev, input int cur, input int k, input int n);
      int a;
      int q;
      a = (cur - prev) * k * recip_tb[n-1];
      q = a / 1024;
      if ((a % 1024) != 0 && a < 0)
         q = q - 1;
      q = prev + q;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   // Expected frame sequence and fetch addresses for one complete play.
   function automatic void build_expected(input bit fast, input bit interp, input int n, input int end_a);
      exp_q.delete();
      exp_addr_q.delete();
      if (fast) begin
         for (int a = 0; a <= end_a; a += n) begin
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
         end
      end else begin
         for (int a = 0; a <= end_a; a++) begin
            exp_addr_q.push_back(a);
            for (int k = 0; k < n; k++)
               exp_q.push_back(interp ? interp_model((a == 0) ? 0 : mem[a-1], mem[a], k, n) : mem[a]);
         end
      end
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge i_bclk);
   endtask

   task automatic clear_monitors();
      cap_q.delete();
      fetch_q.delete();
      done_cnt = 0;
      unstable = 0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      wait_cycles(1);
      i_start = 1'b0;
   endtask

   task automatic set_mode(input bit fast, input bit interp, input int speed, input int end_a);
      i_fast     = fast;
      i_interp   = interp;
      i_speed    = 3'(speed);
      i_end_addr = ADDR_W'(end_a);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (o_done !== 1'b1 && n < budget) begin
         @(negedge i_bclk);
         n++;
      end
      check({tag, "_done_seen"}, int'(o_done), 1);
   endtask

   task automatic wait_captures(input int count, input int budget, input string tag);
      int n = 0;
      while (cap_q.size() < count && n < budget) begin
         @(negedge i_bclk);
         n++;
      end
      check({tag, "_frames_reached"}, int'(cap_q.size() >= count), 1);
   endtask

   task automatic compare_run(input string tag);
      check({tag, "_nsamp"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check($sformatf("%s_samp%0d", tag, i), cap_q[i], exp_q[i]);
      check({tag, "_nfetch"}, fetch_q.size(), exp_addr_q.size());
      for (int i = 0; i < exp_addr_q.size() && i < fetch_q.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), fetch_q[i], exp_addr_q[i]);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_stable_low"}, unstable, 0);
      check({tag, "_en_off"}, int'(o_en), 0);
      check({tag, "_idle"}, int'(o_state), int'(ST_IDLE));
   endtask

   task automatic play(input bit fast, input bit interp, input int speed, input int end_a, input string tag);
      set_mode(fast, interp, speed, end_a);
      build_expected(fast, interp, speed + 1, end_a);
      clear_monitors();
      pulse_start();
      wait_done((exp_q.size() + 4) * 2 * HALF, tag);
      wait_cycles(3);
      compare_run(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int want;

      // ---------------- reset state ----------------
      wait_cycles(3);
      check("rst_en",    int'(o_en), 0);
      check("rst_req",   int'(o_sram_req), 0);
      check("rst_done",  int'(o_done), 0);
      check("rst_data",  int'(o_dac_data), 0);
      check("rst_addr",  int'(o_addr), 0);
      check("rst_state", int'(o_state), int'(ST_IDLE));
      i_rst_n = 1'b1;
      wait_cycles(2);

      // ---------------- interpolator standalone ----------------
      t_prev = 16'sd32767; t_cur = -16'sd32768; t_n_m1 = 3'd7; t_k = 3'd7;
      #1;
      check("interp_extreme", int'(t_out), interp_model(32767, -32768, 7, 8));
      t_prev = -16'sd32768; t_cur = 16'sd32767; t_n_m1 = 3'd0; t_k = 3'd7;
      #1;
      check("interp_sat_hi", int'(t_out), 32767);
      t_prev = 16'sd32767; t_cur = -16'sd32768; t_n_m1 = 3'd1; t_k = 3'd5;
      #1;
      check("interp_sat_lo", int'(t_out), -32768);
      for (int i = 0; i < 40; i++) begin
         t_prev = 16'($urandom);
         t_cur  = 16'($urandom);
         t_n_m1 = 3'($urandom_range(0, 7));
         t_k    = 3'($urandom_range(0, 7));
         #1;
         check($sformatf("interp_rand%0d", i), int'(t_out),
               interp_model(int'(t_prev), int'(t_cur), int'(t_k), int'(t_n_m1) + 1));
      end
      wait_cycles(1);

      // ---------------- directed plays ----------------
      for (int i = 0; i < 64; i++) mem[i] = 100 * (i + 1);
      play(1'b0, 1'b0, 0, 3, "normal");

      for (int i = 0; i < 64; i++) mem[i] = 7 * i - 20;
      play(1'b1, 1'b0, 1, 6, "fast");

      mem[0] = 500; mem[1] = 900;
      play(1'b0, 1'b0, 2, 1, "hold");

      mem[0] = 0; mem[1] = 800; mem[2] = 400;
      play(1'b0, 1'b1, 3, 2, "interp");

      // ---------------- randomized plays ----------------
      for (int r = 0; r < 8; r++) begin
         bit fast;
         for (int i = 0; i < 64; i++) mem[i] = int'($signed(16'($urandom)));
         fast = 1'($urandom_range(0, 1));
         play(fast, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              fast ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 5)),
              $sformatf("rand%0d", r));
      end

      // ---------------- pause mid-frame, then resume ----------------
      for (int i = 0; i < 64; i++) mem[i] = 1000 + 11 * i;
      set_mode(1'b0, 1'b0, 2, 3);
      build_expected(1'b0, 1'b0, 3, 3);
      clear_monitors();
      pulse_start();
      wait_captures(4, 20 * 2 * HALF, "pause");
      wait_cycles(5);
      i_pause = 1'b1;
      wait_cycles(40);
      check("pause_en_off", int'(o_en), 0);
      check("pause_state", int'(o_state), int'(ST_PAUSE));
      wait_cycles(64);
      check("pause_data_zero", int'(o_dac_data), 0);
      check("pause_frames_held", cap_q.size(), 5);
      i_pause = 1'b0;
      wait_done((exp_q.size() + 4) * 2 * HALF, "pause");
      wait_cycles(3);
      compare_run("pause");

      // ---------------- stop while a read is pending ----------------
      set_mode(1'b0, 1'b0, 0, 10);
      clear_monitors();
      hold_ack = 1'b1;
      pulse_start();
      wait_cycles(3);
      check("stopf_req_pending", int'(o_sram_req), 1);
      i_stop = 1'b1;
      wait_cycles(1);
      i_stop = 1'b0;
      wait_cycles(4);
      check("stopf_req_held", int'(o_sram_req), 1);
      check("stopf_still_fetch", int'(o_state), int'(ST_FETCH));
      check("stopf_no_done_yet", done_cnt, 0);
      hold_ack = 1'b0;
      wait_cycles(8);
      check("stopf_idle", int'(o_state), int'(ST_IDLE));
      check("stopf_req_low", int'(o_sram_req), 0);
      check("stopf_done_once", done_cnt, 1);
      check("stopf_en_off", int'(o_en), 0);

      // ---------------- stop during playback ----------------
      for (int i = 0; i < 64; i++) mem[i] = 300 + i;
      set_mode(1'b0, 1'b0, 0, 10);
      clear_monitors();
      pulse_start();
      wait_captures(2, 10 * 2 * HALF, "stopp");
      wait_cycles(3);
      i_stop = 1'b1;
      wait_cycles(1);
      i_stop = 1'b0;
      wait_cycles(8);
      check("stopp_idle", int'(o_state), int'(ST_IDLE));
      check("stopp_en_off", int'(o_en), 0);
      check("stopp_data_zero", int'(o_dac_data), 0);
      check("stopp_done_once", done_cnt, 1);

      // ---------------- start and stop together ----------------
      clear_monitors();
      i_start = 1'b1;
      i_stop  = 1'b1;
      wait_cycles(1);
      i_start = 1'b0;
      i_stop  = 1'b0;
      wait_cycles(3);
      check("startstop_idle", int'(o_state), int'(ST_IDLE));
      check("startstop_no_req", int'(o_sram_req), 0);
      check("startstop_no_fetch", fetch_q.size(), 0);

      // ---------------- reset while a read is pending ----------------
      hold_ack = 1'b1;
      pulse_start();
      wait_cycles(3);
      check("rstf_req_pending", int'(o_sram_req), 1);
      #2 i_rst_n = 1'b0;
      #1;
      check("rstf_req_drop", int'(o_sram_req), 0);
      check("rstf_state", int'(o_state), int'(ST_IDLE));
      want = 0;
      check("rstf_en", int'(o_en), want);
      @(negedge i_bclk);
      i_rst_n  = 1'b1;
      hold_ack = 1'b0;
      wait_cycles(4);
      check("rstf_idle_after", int'(o_state), int'(ST_IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
